// File: rtl/duck_round_ctl_if.sv
// rtl/duck_round_ctl_if.sv - signal bundle between the game control layer and duck_round_ctl
//
// Groups every non-clock, non-reset signal of duck_round_ctl.
//   master : game control / mouse / duck_ctl side (drives inputs, observes status)
//   slave  : duck_round_ctl itself
//
// Signals:
//   game_enable   1   high while the game state is active
//   frame_tick    1   one-cycle pulse per frame
//   left_mouse    1   left button level, clk domain
//   mouse_xpos    12  cursor x
//   mouse_ypos    12  cursor y
//   duck_xpos     12  duck top-left x
//   duck_ypos     12  duck top-left y
//   duck_spawn    1   one-cycle pulse, duck_ctl loads a new start position
//   duck_active   1   duck flying and shootable
//   duck_hit      1   hit animation phase
//   shots_left    2   shots remaining for the current duck
//   duck_count    4   ducks launched so far
//   score         8   ducks hit (binary, or two BCD digits with SCORE_BCD_EN)
//   game_finished 1   level, game over

interface duck_round_ctl_if;
  logic        game_enable;
  logic        frame_tick;
  logic        left_mouse;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic [11:0] duck_xpos;
  logic [11:0] duck_ypos;
  logic        duck_spawn;
  logic        duck_active;
  logic        duck_hit;
  logic [1:0]  shots_left;
  logic [3:0]  duck_count;
  logic [7:0]  score;
  logic        game_finished;

  modport master (
    output game_enable, frame_tick, left_mouse,
    output mouse_xpos, mouse_ypos, duck_xpos, duck_ypos,
    input  duck_spawn, duck_active, duck_hit,
    input  shots_left, duck_count, score, game_finished
  );

  modport slave (
    input  game_enable, frame_tick, left_mouse,
    input  mouse_xpos, mouse_ypos, duck_xpos, duck_ypos,
    output duck_spawn, duck_active, duck_hit,
    output shots_left, duck_count, score, game_finished
  );
endinterface

// File: rtl/duck_round_ctl.sv
// rtl/duck_round_ctl.sv - sequences one game of duck hunting: spawn, shots, flight time, hits, score
//
// Ports:
//   clk  system pixel clock
//   rst  asynchronous active-low reset
//   bus  duck_round_ctl_if.slave (game_enable, frame_tick, mouse, duck position in;
//        duck_spawn, duck_active, duck_hit, shots_left, duck_count, score,
//        game_finished out)
//
// Optional feature macro: SCORE_BCD_EN
//   defined     : score[7:4] tens digit, score[3:0] units digit
//   not defined : score is plain 8-bit binary

module duck_round_ctl #(
  parameter int DUCKS_PER_GAME = 10,
  parameter int SHOTS_PER_DUCK = 3,
  parameter int FLY_FRAMES     = 300,
  parameter int HIT_FRAMES     = 30,
  parameter int DUCK_WIDTH     = 64,
  parameter int DUCK_HEIGHT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  duck_round_ctl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_FLY,
    S_HIT,
    S_ESCAPE,
    S_NEXT,
    S_OVER
  } state_t;

  state_t      state, state_n;
  logic        left_d;
  logic [9:0]  frame_cnt, frame_n;
  logic [1:0]  shots, shots_n;
  logic [3:0]  count, count_n;
  logic [7:0]  score, score_n;

  logic        spawn_o, active_o, hit_o, finished_o;

  logic        click;
  logic        in_box;
  logic        fly_timeout;
  logic        hold_done;

  // Extended to 13 bits so a duck near the right/bottom edge does not wrap
  // its far hitbox boundary back to a small value.
  logic [12:0] mx13, my13, dx13, dy13, dx_end, dy_end;

  assign click = bus.left_mouse & ~left_d;

  assign mx13   = {1'b0, bus.mouse_xpos};
  assign my13   = {1'b0, bus.mouse_ypos};
  assign dx13   = {1'b0, bus.duck_xpos};
  assign dy13   = {1'b0, bus.duck_ypos};
  assign dx_end = dx13 + 13'(DUCK_WIDTH);
  assign dy_end = dy13 + 13'(DUCK_HEIGHT);

  assign in_box = (mx13 >= dx13) && (mx13 < dx_end) &&
                  (my13 >= dy13) && (my13 < dy_end);

  // Timeouts fire on the tick that would take the counter past the limit.
  assign fly_timeout = bus.frame_tick && (frame_cnt == 10'(FLY_FRAMES - 1));
  assign hold_done   = bus.frame_tick && (frame_cnt == 10'(HIT_FRAMES - 1));

  function automatic logic [7:0] score_inc(input logic [7:0] s);
    logic [7:0] r;
`ifdef SCORE_BCD_EN
    if (s[3:0] == 4'd9) begin
      r = {s[7:4] + 4'd1, 4'd0};
    end else begin
      r = {s[7:4], s[3:0] + 4'd1};
    end
`else
    r = s + 8'd1;
`endif
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      left_d    <= 1'b0;
      frame_cnt <= '0;
      shots     <= '0;
      count     <= '0;
      score     <= '0;
    end else begin
      state     <= state_n;
      left_d    <= bus.left_mouse;
      frame_cnt <= frame_n;
      shots     <= shots_n;
      count     <= count_n;
      score     <= score_n;
    end
  end

  always_comb begin
    state_n    = state;
    frame_n    = frame_cnt;
    shots_n    = shots;
    count_n    = count;
    score_n    = score;
    spawn_o    = 1'b0;
    active_o   = 1'b0;
    hit_o      = 1'b0;
    finished_o = 1'b0;

    if (bus.frame_tick) begin
      frame_n = frame_cnt + 10'd1;
    end

    case (state)
      S_IDLE: begin
        if (bus.game_enable) begin
          state_n = S_SPAWN;
        end
      end

      S_SPAWN: begin
        spawn_o = 1'b1;
        state_n = S_FLY;
      end

      S_FLY: begin
        active_o = 1'b1;
        // A click is judged before the flight timeout so a hit on the
        // last frame still counts.
        if (click) begin
          if (shots != 2'd0) begin
            shots_n = shots - 2'd1;
          end
          if (in_box) begin
            state_n = S_HIT;
            score_n = score_inc(score);
          end else if (shots <= 2'd1 || fly_timeout) begin
            state_n = S_ESCAPE;
          end
        end else if (fly_timeout) begin
          state_n = S_ESCAPE;
        end
      end

      S_HIT: begin
        hit_o = 1'b1;
        if (hold_done) begin
          state_n = S_NEXT;
        end
      end

      S_ESCAPE: begin
        if (hold_done) begin
          state_n = S_NEXT;
        end
      end

      S_NEXT: begin
        if (count == 4'(DUCKS_PER_GAME)) begin
          state_n = S_OVER;
        end else begin
          state_n = S_SPAWN;
        end
      end

      S_OVER: begin
        finished_o = 1'b1;
        if (!bus.game_enable) begin
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Losing game_enable mid-round abandons the game immediately.
    if (!bus.game_enable && state != S_IDLE && state != S_OVER) begin
      state_n = S_IDLE;
    end

    // SPAWN is only ever entered from IDLE or NEXT, so this is its entry.
    if (state_n == S_SPAWN) begin
      count_n = count + 4'd1;
      shots_n = 2'(SHOTS_PER_DUCK);
    end

    if (state_n != state) begin
      frame_n = '0;
    end

    if (state_n == S_IDLE) begin
      frame_n = '0;
      shots_n = '0;
      count_n = '0;
      score_n = '0;
    end
  end

  assign bus.duck_spawn    = spawn_o;
  assign bus.duck_active   = active_o;
  assign bus.duck_hit      = hit_o;
  assign bus.game_finished = finished_o;
  assign bus.shots_left    = shots;
  assign bus.duck_count    = count;
  assign bus.score         = score;

endmodule

// File: tb/tb_duck_round_ctl.sv
// tb/tb_duck_round_ctl.sv - self-checking bench for duck_round_ctl

module tb_duck_round_ctl;

  localparam int N_DUCKS = 10;
  localparam int N_SHOTS = 3;
  localparam int FF      = 300;
  localparam int HF      = 30;
  localparam int DW      = 64;
  localparam int DH      = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  duck_round_ctl_if bus ();

  duck_round_ctl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Game-level model: ducks launched, ducks hit, shots left for this duck.
  int m_count = 0;
  int m_hits  = 0;
  int m_shots = 0;
  int dx = 0;
  int dy = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_score(input int hits);
`ifdef SCORE_BCD_EN
    return (hits / 10) * 16 + (hits % 10);
`else
    return hits;
`endif
  endfunction

  function automatic bit in_box(input int mx, input int my, input int x0, input int y0);
    return (mx >= x0) && (mx < x0 + DW) && (my >= y0) && (my < y0 + DH);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit e_spawn, input bit e_active,
                           input bit e_hit, input bit e_fin);
    check({tag, ".spawn"},    32'(bus.duck_spawn),    32'(e_spawn));
    check({tag, ".active"},   32'(bus.duck_active),   32'(e_active));
    check({tag, ".hit"},      32'(bus.duck_hit),      32'(e_hit));
    check({tag, ".finished"}, 32'(bus.game_finished), 32'(e_fin));
    check({tag, ".shots"},    32'(bus.shots_left),    32'(m_shots));
    check({tag, ".count"},    32'(bus.duck_count),    32'(m_count));
    check({tag, ".score"},    32'(bus.score),         32'(exp_score(m_hits)));
  endtask

  task automatic set_duck(input int x, input int y);
    dx = x;
    dy = y;
    bus.duck_xpos = 12'(x);
    bus.duck_ypos = 12'(y);
  endtask

  task automatic tick_frames(input int n);
    repeat (n) begin
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      step();
    end
  endtask

  // One click (optionally coincident with a frame tick), model update, check.
  // phase: 0 still flying, 1 hit, 2 escaped.
  task automatic shoot(input string tag, input int x, input int y, input bit with_tick,
                       output int phase);
    bus.mouse_xpos = 12'(x);
    bus.mouse_ypos = 12'(y);
    bus.left_mouse = 1'b1;
    bus.frame_tick = with_tick;
    step();
    bus.left_mouse = 1'b0;
    bus.frame_tick = 1'b0;
    step();
    if (m_shots > 0) m_shots--;
    if (in_box(x, y, dx, dy)) begin
      m_hits++;
      phase = 1;
    end else if (m_shots == 0) begin
      phase = 2;
    end else begin
      phase = 0;
    end
    check_all(tag, 1'b0, phase == 0, phase == 1, 1'b0);
  endtask

  // Runs the hold phase of a hit/escape and enters the next duck or game over.
  task automatic finish_duck(input string tag, input int phase);
    tick_frames(HF - 1);
    check_all({tag, ".hold"}, 1'b0, 1'b0, phase == 1, 1'b0);
    tick_frames(1);
    if (m_count < N_DUCKS) begin
      m_count++;
      m_shots = N_SHOTS;
      check_all({tag, ".spawn"}, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check_all({tag, ".fly"}, 1'b0, 1'b1, 1'b0, 1'b0);
    end else begin
      check_all({tag, ".over"}, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic pick_hit(output int x, output int y);
    int lx;
    int ly;
    lx = 4095 - dx;
    ly = 4095 - dy;
    if (lx > DW - 1) lx = DW - 1;
    if (ly > DH - 1) ly = DH - 1;
    x = dx + int'($urandom_range(0, lx));
    y = dy + int'($urandom_range(0, ly));
  endtask

  task automatic pick_miss(output int x, output int y);
    int tries;
    tries = 0;
    do begin
      x = int'($urandom_range(0, 4095));
      y = int'($urandom_range(0, 4095));
      tries++;
    end while (in_box(x, y, dx, dy) && tries < 100);
    if (in_box(x, y, dx, dy)) begin
      x = (dx >= 1) ? dx - 1 : dx + DW;
    end
  endtask

  initial begin
    int ph;
    int mx;
    int my;
    int k;

    bus.game_enable = 1'b0;
    bus.frame_tick  = 1'b0;
    bus.left_mouse  = 1'b0;
    bus.mouse_xpos  = '0;
    bus.mouse_ypos  = '0;
    set_duck(100, 100);

    repeat (2) step();
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // game_enable high while still in reset, then release.
    bus.game_enable = 1'b1;
    step();
    check_all("reset_held", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    m_count = 1;
    m_shots = N_SHOTS;
    check_all("first_spawn", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_all("first_fly", 1'b0, 1'b1, 1'b0, 1'b0);

    // Duck 1: hit inside the box.
    shoot("d1_hit", 130, 150, 1'b0, ph);
    finish_duck("d1", ph);

    // Duck 2: three misses then escape.
    for (int i = 0; i < 3; i++) begin
      shoot("d2_miss", 400, 400, 1'b0, ph);
    end
    finish_duck("d2", ph);

    // Duck 3: right edge of hitbox.
    shoot("d3_x164", 164, 120, 1'b0, ph);
    shoot("d3_x163", 163, 120, 1'b0, ph);
    finish_duck("d3", ph);

    // Duck 4: hit click on the same cycle as the timeout tick.
    tick_frames(FF - 1);
    check_all("d4_pre_timeout", 1'b0, 1'b1, 1'b0, 1'b0);
    shoot("d4_simul", 110, 110, 1'b1, ph);
    finish_duck("d4", ph);

    // Duck 5: pure flight timeout.
    tick_frames(FF);
    check_all("d5_timeout", 1'b0, 1'b0, 1'b0, 1'b0);
    finish_duck("d5", 2);

    // Ducks 6..10: random positions, 6..8 hit after random misses, 9..10 escape.
    for (int d = 6; d <= N_DUCKS; d++) begin
      if (d == 6) set_duck(4032 + int'($urandom_range(0, 63)), 4032 + int'($urandom_range(0, 63)));
      else        set_duck(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
      if (d <= 8) begin
        k = int'($urandom_range(0, 2));
        for (int i = 0; i < k; i++) begin
          pick_miss(mx, my);
          shoot("rnd_miss", mx, my, 1'b0, ph);
        end
        pick_hit(mx, my);
        shoot("rnd_hit", mx, my, 1'b0, ph);
      end else begin
        for (int i = 0; i < 3; i++) begin
          pick_miss(mx, my);
          shoot("rnd_esc", mx, my, 1'b0, ph);
        end
      end
      finish_duck("rnd", ph);
    end

    check("game_hits_model", 32'(bus.score), 32'(exp_score(6)));

    // Clicks during OVER are ignored and results held.
    bus.mouse_xpos = bus.duck_xpos;
    bus.mouse_ypos = bus.duck_ypos;
    bus.left_mouse = 1'b1;
    step();
    bus.left_mouse = 1'b0;
    step();
    check_all("over_click", 1'b0, 1'b0, 1'b0, 1'b1);

    bus.game_enable = 1'b0;
    step();
    m_count = 0;
    m_hits  = 0;
    m_shots = 0;
    check_all("over_to_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Button held across SPAWN produces no click; then drop enable mid-FLY.
    set_duck(200, 200);
    bus.left_mouse  = 1'b1;
    bus.game_enable = 1'b1;
    step();
    m_count = 1;
    m_shots = N_SHOTS;
    check_all("held_spawn", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check_all("held_fly", 1'b0, 1'b1, 1'b0, 1'b0);
    bus.left_mouse = 1'b0;
    step();
    shoot("drop_miss", 1000, 1000, 1'b0, ph);
    bus.game_enable = 1'b0;
    step();
    m_count = 0;
    m_shots = 0;
    check_all("drop_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-FLY, release with game_enable high.
    bus.game_enable = 1'b1;
    step();
    m_count = 1;
    m_shots = N_SHOTS;
    step();
    shoot("rst_miss", 1000, 1000, 1'b0, ph);
    #2;
    rst = 1'b0;
    #1;
    m_count = 0;
    m_hits  = 0;
    m_shots = 0;
    check_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    step();
    m_count = 1;
    m_shots = N_SHOTS;
    check_all("rst_release_spawn", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_all("rst_release_fly", 1'b0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
